// File: rtl/uart_rx_ctrl_if.sv
// rtl/uart_rx_ctrl_if.sv - receive character stream between uart_rx_ctrl and its consumer
interface uart_rx_ctrl_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] m_data;
  logic                 m_parity_err;
  logic                 m_frame_err;
  logic                 m_valid;
  logic                 m_ready;

  modport master (
    output m_data, m_parity_err, m_frame_err, m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data, m_parity_err, m_frame_err, m_valid,
    output m_ready
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive controller: 16x tick, parity mode, character FIFO, status
module uart_rx_ctrl #(
  parameter int DATA_BITS  = 8,
  parameter int DIV_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          cfg_enable,
  input  logic [DIV_WIDTH-1:0]          cfg_div,
  input  logic                          cfg_parity_enable,
  input  logic                          cfg_drop_errored,
  input  logic                          clear_status,
  output logic                          tick_16x,
  output logic                          parity_enable,
  input  logic [DATA_BITS-1:0]          rx_data,
  input  logic                          data_ready,
  input  logic                          parity_err,
  input  logic                          frame_err,
  uart_rx_ctrl_if.master                m,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overrun,
  output logic [7:0]                    err_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = DATA_BITS + 2;

  logic [DIV_WIDTH-1:0] div_cnt;
  logic                 dr_q;
  logic [EW-1:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [EW-1:0]        head;
  logic                 evt;
  logic                 err_flag;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 wr_en;
  logic                 ovf;

  always_comb begin
    err_flag = parity_err | frame_err;
    evt      = cfg_enable & data_ready & ~dr_q;
    push     = evt & ~(cfg_drop_errored & err_flag);
    pop      = m.m_valid & m.m_ready;
    full     = (fifo_level == LW'(FIFO_DEPTH));
    // A pop frees the slot on the same edge, so a full FIFO can still accept.
    wr_en    = push & (~full | pop);
    ovf      = push & full & ~pop;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt  <= '0;
      tick_16x <= 1'b0;
    end else if (!cfg_enable) begin
      div_cnt  <= '0;
      tick_16x <= 1'b0;
    end else if (div_cnt >= cfg_div) begin
      div_cnt  <= '0;
      tick_16x <= 1'b1;
    end else begin
      div_cnt  <= div_cnt + DIV_WIDTH'(1);
      tick_16x <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      parity_enable <= 1'b0;
      dr_q          <= 1'b0;
    end else begin
      dr_q <= data_ready;
      if (!cfg_enable) parity_enable <= cfg_parity_enable;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {frame_err, parity_err, rx_data};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Clear wins over a same-cycle set or increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun   <= 1'b0;
      err_count <= '0;
    end else if (clear_status) begin
      overrun   <= 1'b0;
      err_count <= '0;
    end else begin
      if (ovf) overrun <= 1'b1;
      if (evt && err_flag && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

  assign head           = mem[rd_ptr];
  assign m.m_valid      = (fifo_level != '0);
  assign m.m_data       = m.m_valid ? head[DATA_BITS-1:0] : '0;
  assign m.m_parity_err = m.m_valid & head[DATA_BITS];
  assign m.m_frame_err  = m.m_valid & head[DATA_BITS+1];
endmodule
